// File: rtl/labs_pkg.sv
// Shared definitions for the LABS best-sequence tracker.
// Holds the register map, CTRL/STATUS bit positions, reset-related widths,
// the saturating counter helpers and the parameter range check.
// The optional history FIFO is enabled with the LABS_TRACK_HIST_EN macro.
package labs_pkg;

  // Word offsets decoded from wbs_adr_i[4:2]
  typedef enum logic [2:0] {
    REG_STATUS = 3'd0,
    REG_EVALS  = 3'd1,
    REG_BEST_E = 3'd2,
    REG_SEQ_LO = 3'd3,
    REG_SEQ_HI = 3'd4,
    REG_THRESH = 3'd5,
    REG_CTRL   = 3'd6,
    REG_HIST   = 3'd7
  } reg_off_e;

  localparam int CTRL_CLEAR_BIT  = 0;
  localparam int CTRL_STOP_BIT   = 1;
  localparam int STAT_VLD_BIT    = 0;
  localparam int STAT_HIT_BIT    = 1;
  localparam int STAT_NEMPTY_BIT = 2;
  localparam int HIST_FLAG_BIT   = 31;
  localparam int HIST_DEPTH      = 4;

  localparam int TIES_W  = 16;
  localparam int EVALS_W = 32;

  localparam int SEQ_WIDTH_MIN = 33;
  localparam int SEQ_WIDTH_MAX = 64;
  localparam int E_WIDTH_MAX   = 32;

  localparam logic [3:0] WB_SEL_FULL = 4'hF;

  // Legal parameter ranges: SEQ_HI must hold 1..32 bits, energy fits one word
  function automatic bit widths_ok(input int seq_w, input int e_w);
    return (seq_w >= SEQ_WIDTH_MIN) && (seq_w <= SEQ_WIDTH_MAX) &&
           (e_w >= 1) && (e_w <= E_WIDTH_MAX);
  endfunction

  function automatic logic [EVALS_W-1:0] sat_inc_evals(input logic [EVALS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [TIES_W-1:0] sat_inc_ties(input logic [TIES_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/labs_hist_fifo.sv
// Four-deep history of best-energy values, oldest entry dropped when a push
// arrives while full. Only instantiated when LABS_TRACK_HIST_EN is defined.
module labs_hist_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         nempty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          full, do_pop, drop;

  assign full     = (cnt_q == (PW+1)'(DEPTH));
  assign do_pop   = pop_i && (cnt_q != '0);
  // A push into a full FIFO without a simultaneous pop evicts the oldest entry
  assign drop     = push_i && !do_pop && full;
  assign head_o   = mem_q[rd_q];
  assign nempty_o = (cnt_q != '0);

  // Pointer and occupancy next-state
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i)         wr_d = wr_q + 1'b1;
      if (do_pop || drop) rd_d = rd_q + 1'b1;
      if (do_pop && !push_i)                cnt_d = cnt_q - 1'b1;
      else if (push_i && !do_pop && !full)  cnt_d = cnt_q + 1'b1;
    end
  end

  // Control state: pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array, validity is tracked by cnt_q so no reset is needed
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/labs_best_tracker.sv
// LABS best-sequence tracker: consumes (sequence, energy) results, keeps the
// minimum-energy sequence, tie and evaluation counts, raises a sticky
// threshold interrupt and exposes everything over a Wishbone slave.
// Optional history FIFO: define LABS_TRACK_HIST_EN.
module labs_best_tracker
  import labs_pkg::*;
#(
  parameter int          SEQ_WIDTH = 64,
  parameter int          E_WIDTH   = 20,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic [31:0]          wbs_dat_o,
  output logic                 wbs_ack_o,
  input  logic                 res_valid_i,
  output logic                 res_ready_o,
  input  logic [SEQ_WIDTH-1:0] res_seq_i,
  input  logic [E_WIDTH-1:0]   res_e_i,
  output logic                 irq_o
);

  if (!widths_ok(SEQ_WIDTH, E_WIDTH)) begin : g_bad_widths
    $error("labs_best_tracker: SEQ_WIDTH must be 33..64 and E_WIDTH 1..32");
  end

  logic                 ack_q, ack_d;
  logic                 s1_vld_q, s1_vld_d;
  logic [SEQ_WIDTH-1:0] s1_seq_q;
  logic [E_WIDTH-1:0]   s1_e_q;
  logic [E_WIDTH-1:0]   best_e_q, best_e_d;
  logic [SEQ_WIDTH-1:0] best_seq_q, best_seq_d;
  logic                 best_vld_q, best_vld_d;
  logic [TIES_W-1:0]    ties_q, ties_d;
  logic [EVALS_W-1:0]   evals_q, evals_d;
  logic                 hit_q, hit_d;
  logic [E_WIDTH-1:0]   thresh_q, thresh_d;
  logic                 stop_q, stop_d;
  logic                 ready_q, ready_d;
  logic [SEQ_WIDTH-33:0] shadow_q, shadow_d;

  reg_off_e    off;
  logic        addr_match, wb_req, wb_fire, wb_rd, wb_wr;
  logic        ctrl_wr, thresh_wr, clr, shadow_ld;
  logic        xfer, improve, tie;
  logic        hist_nempty;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i};

  // Wishbone decode: any word inside the 32-byte window is acknowledged
  assign off        = reg_off_e'(wbs_adr_i[4:2]);
  assign addr_match = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign wb_req     = wbs_stb_i && wbs_cyc_i && addr_match;
  // Side effects are taken on the ack cycle, while the master still holds the request
  assign wb_fire    = ack_q && wbs_stb_i && wbs_cyc_i;
  assign wb_rd      = wb_fire && !wbs_we_i;
  assign wb_wr      = wb_fire && wbs_we_i && (wbs_sel_i == WB_SEL_FULL);
  assign ctrl_wr    = wb_wr && (off == REG_CTRL);
  assign thresh_wr  = wb_wr && (off == REG_THRESH);
  assign clr        = ctrl_wr && wbs_dat_i[CTRL_CLEAR_BIT];
  assign shadow_ld  = wb_rd && (off == REG_SEQ_LO);

  // Result stream: S1 holds the accepted sample, S2 is the compare below
  assign xfer    = res_valid_i && res_ready_o;
  assign improve = s1_vld_q && !clr && (!best_vld_q || (s1_e_q < best_e_q));
  assign tie     = s1_vld_q && !clr && best_vld_q && (s1_e_q == best_e_q);

`ifdef LABS_TRACK_HIST_EN
  logic               hist_pop;
  logic [E_WIDTH-1:0] hist_head;

  assign hist_pop = wb_rd && (off == REG_HIST);

  labs_hist_fifo #(
    .W     (E_WIDTH),
    .DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_ni),
    .clr_i    (clr),
    .push_i   (improve),
    .data_i   (s1_e_q),
    .pop_i    (hist_pop),
    .head_o   (hist_head),
    .nempty_o (hist_nempty)
  );
`else
  assign hist_nempty = 1'b0;
`endif

  // Next-state for tracking, control and bus registers; clear beats any update
  always_comb begin
    ack_d      = wb_req && !ack_q;
    s1_vld_d   = xfer && !clr;
    thresh_d   = thresh_wr ? wbs_dat_i[E_WIDTH-1:0] : thresh_q;
    stop_d     = ctrl_wr ? wbs_dat_i[CTRL_STOP_BIT] : stop_q;
    shadow_d   = shadow_ld ? best_seq_q[SEQ_WIDTH-1:32] : shadow_q;
    best_e_d   = best_e_q;
    best_seq_d = best_seq_q;
    best_vld_d = best_vld_q;
    ties_d     = ties_q;
    evals_d    = evals_q;
    hit_d      = hit_q;
    if (clr) begin
      best_e_d   = '1;
      best_seq_d = '0;
      best_vld_d = 1'b0;
      ties_d     = '0;
      evals_d    = '0;
      hit_d      = 1'b0;
    end else begin
      // Hit looks at the already-updated best, so it trails the update by a cycle
      hit_d = hit_q || (best_vld_q && (best_e_q <= thresh_q));
      if (s1_vld_q) evals_d = sat_inc_evals(evals_q);
      if (improve) begin
        best_e_d   = s1_e_q;
        best_seq_d = s1_seq_q;
        best_vld_d = 1'b1;
        ties_d     = '0;
      end else if (tie) begin
        ties_d = sat_inc_ties(ties_q);
      end
    end
    ready_d = !(stop_d && hit_d);
  end

  // Register update for all control and visible state
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q      <= 1'b0;
      s1_vld_q   <= 1'b0;
      best_e_q   <= '1;
      best_seq_q <= '0;
      best_vld_q <= 1'b0;
      ties_q     <= '0;
      evals_q    <= '0;
      hit_q      <= 1'b0;
      thresh_q   <= '0;
      stop_q     <= 1'b0;
      ready_q    <= 1'b0;
      shadow_q   <= '0;
    end else begin
      ack_q      <= ack_d;
      s1_vld_q   <= s1_vld_d;
      best_e_q   <= best_e_d;
      best_seq_q <= best_seq_d;
      best_vld_q <= best_vld_d;
      ties_q     <= ties_d;
      evals_q    <= evals_d;
      hit_q      <= hit_d;
      thresh_q   <= thresh_d;
      stop_q     <= stop_d;
      ready_q    <= ready_d;
      shadow_q   <= shadow_d;
    end
  end

  // S1 sample payload, qualified by s1_vld_q
  always_ff @(posedge wb_clk_i) begin
    if (xfer) begin
      s1_seq_q <= res_seq_i;
      s1_e_q   <= res_e_i;
    end
  end

  // Read mux, driven onto the bus only during the ack cycle
  always_comb begin
    rd_data = '0;
    case (off)
      REG_STATUS: begin
        rd_data[STAT_VLD_BIT]    = best_vld_q;
        rd_data[STAT_HIT_BIT]    = hit_q;
        rd_data[STAT_NEMPTY_BIT] = hist_nempty;
      end
      REG_EVALS:  rd_data = evals_q;
      REG_BEST_E: rd_data[E_WIDTH-1:0] = best_e_q;
      REG_SEQ_LO: rd_data = best_seq_q[31:0];
      REG_SEQ_HI: rd_data[SEQ_WIDTH-33:0] = shadow_q;
      REG_THRESH: rd_data[E_WIDTH-1:0] = thresh_q;
      REG_CTRL:   rd_data[CTRL_STOP_BIT] = stop_q;
      REG_HIST: begin
`ifdef LABS_TRACK_HIST_EN
        if (hist_nempty) begin
          rd_data[HIST_FLAG_BIT]  = 1'b1;
          rd_data[E_WIDTH-1:0]    = hist_head;
        end
`endif
      end
      default: rd_data = '0;
    endcase
  end

  assign wbs_dat_o   = ack_q ? rd_data : 32'h0;
  assign wbs_ack_o   = ack_q;
  assign res_ready_o = ready_q;
  assign irq_o       = hit_q;

endmodule

// File: tb/tb_labs_best_tracker.sv
// Directed bench for labs_best_tracker: table-driven result stream plus
// hand-written sequences for stop/hit, clear collision, SEQ shadow,
// history FIFO (LABS_TRACK_HIST_EN) and asynchronous reset.
module tb_labs_best_tracker;

  localparam logic [31:0] BASE     = 32'h3000_0100;
  localparam logic [31:0] A_STATUS = BASE + 32'h00;
  localparam logic [31:0] A_EVALS  = BASE + 32'h04;
  localparam logic [31:0] A_BEST_E = BASE + 32'h08;
  localparam logic [31:0] A_SEQ_LO = BASE + 32'h0C;
  localparam logic [31:0] A_SEQ_HI = BASE + 32'h10;
  localparam logic [31:0] A_THRESH = BASE + 32'h14;
  localparam logic [31:0] A_CTRL   = BASE + 32'h18;
  localparam logic [31:0] A_HIST   = BASE + 32'h1C;

  logic        clk, rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat;
  logic        ack;
  logic        rvalid, rready, irq;
  logic [63:0] rseq;
  logic [19:0] re;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] seq;
    logic [19:0] e;
    logic [31:0] exp_best;
    logic [31:0] exp_evals;
  } vec_t;

  vec_t tbl [4];

  labs_best_tracker #(
    .SEQ_WIDTH (64),
    .E_WIDTH   (20),
    .BASE_ADDR (BASE)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_dat_o   (rdat),
    .wbs_ack_o   (ack),
    .res_valid_i (rvalid),
    .res_ready_o (rready),
    .res_seq_i   (rseq),
    .res_e_i     (re),
    .irq_o       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that ends the ack cycle
  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    bit got;
    got = 1'b0;
    d   = 32'h0;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF; adr = a;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1;
        d   = rdat;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL wb_read_ack adr=%h: got no ack expected ack", a);
    end else begin
      @(posedge clk); #1;
    end
    stb = 1'b0; cyc = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit got;
    got = 1'b0;
    stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = s; adr = a; wdat = d;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) got = 1'b1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL wb_write_ack adr=%h: got no ack expected ack", a);
    end else begin
      @(posedge clk); #1;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(a, d);
    chk(name, {32'h0, d}, {32'h0, exp});
  endtask

  // Address outside the window must never be acknowledged
  task automatic wb_noack(input string name, input logic [31:0] a);
    logic seen;
    seen = 1'b0;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF; adr = a;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack) seen = 1'b1;
    end
    stb = 1'b0; cyc = 1'b0;
    chk(name, {63'h0, seen}, 64'h0);
  endtask

  // One-cycle result transfer; called #1 after a rising edge
  task automatic push(input logic [63:0] s, input logic [19:0] e);
    rvalid = 1'b1; rseq = s; re = e;
    @(posedge clk); #1;
    rvalid = 1'b0;
  endtask

  initial begin
    logic [31:0] d;

    tbl[0] = '{64'hAAAA_0001_AAAA_0001, 20'd300, 32'd300, 32'd1};
    tbl[1] = '{64'hBBBB_0002_BBBB_0002, 20'd120, 32'd120, 32'd2};
    tbl[2] = '{64'hCCCC_0003_CCCC_0003, 20'd120, 32'd120, 32'd3};
    tbl[3] = '{64'hDDDD_0004_DDDD_0004, 20'd500, 32'd120, 32'd4};

    stb = 0; cyc = 0; we = 0; sel = 4'h0; adr = '0; wdat = '0;
    rvalid = 0; rseq = '0; re = '0;

    // Reset state: every output low while reset is held
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    chk("rst_ack",   {63'h0, ack},    64'h0);
    chk("rst_dat",   {32'h0, rdat},   64'h0);
    chk("rst_irq",   {63'h0, irq},    64'h0);
    chk("rst_ready", {63'h0, rready}, 64'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {63'h0, rready}, 64'h1);
    rd_chk("rst_best_e", A_BEST_E, 32'h000F_FFFF);
    rd_chk("rst_status", A_STATUS, 32'h0);
    rd_chk("rst_evals",  A_EVALS,  32'h0);
    chk("ack_one_cycle", {63'h0, ack}, 64'h0);

    // Test 1: table-driven stream 300,120,120,500
    for (int i = 0; i < 4; i++) begin
      push(tbl[i].seq, tbl[i].e);
      repeat (2) @(posedge clk);
      #1;
      rd_chk($sformatf("t1_best_e[%0d]", i), A_BEST_E, tbl[i].exp_best);
      rd_chk($sformatf("t1_evals[%0d]", i),  A_EVALS,  tbl[i].exp_evals);
    end
    rd_chk("t1_seq_lo", A_SEQ_LO, 32'hBBBB_0002);
    rd_chk("t1_seq_hi", A_SEQ_HI, 32'hBBBB_0002);
    chk("t1_ties", {48'h0, dut.ties_q}, 64'd1);
    rd_chk("t1_status", A_STATUS, 32'h1);
    chk("t1_irq", {63'h0, irq}, 64'h0);

    // Read-only, partial-select and out-of-window accesses
    wb_write(A_EVALS, 32'h1234, 4'hF);
    rd_chk("ro_evals", A_EVALS, 32'd4);
    wb_write(A_THRESH, 32'd77, 4'h3);
    rd_chk("sel_partial_thresh", A_THRESH, 32'h0);
    wb_noack("noack_above", BASE + 32'h20);
    wb_noack("noack_below", BASE - 32'h4);

    // Test 2: threshold hit with stop holds off the producer
    wb_write(A_THRESH, 32'd100, 4'hF);
    rd_chk("t2_thresh", A_THRESH, 32'd100);
    wb_write(A_CTRL, 32'h2, 4'hF);
    rd_chk("t2_ctrl", A_CTRL, 32'h2);
    push(64'hEEEE_0005_EEEE_0005, 20'd99);
    chk("t2_irq_c0", {63'h0, irq}, 64'h0);
    @(posedge clk); #1;
    chk("t2_irq_c1", {63'h0, irq}, 64'h0);
    @(posedge clk); #1;
    chk("t2_irq_c2", {63'h0, irq}, 64'h1);
    chk("t2_ready", {63'h0, rready}, 64'h0);
    rvalid = 1'b1; rseq = 64'h5; re = 20'd5;
    repeat (5) @(posedge clk);
    #1 rvalid = 1'b0;
    rd_chk("t2_evals_held", A_EVALS,  32'd5);
    rd_chk("t2_best_e",     A_BEST_E, 32'd99);
    rd_chk("t2_status",     A_STATUS, 32'h3);
    chk("t2_ties", {48'h0, dut.ties_q}, 64'd0);

    // Test 3: clear lands while S1 holds e=10
    wb_write(A_CTRL, 32'h0, 4'hF);
    chk("t3_ready_unstop", {63'h0, rready}, 64'h1);
    chk("t3_irq_sticky",   {63'h0, irq},    64'h1);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = 4'hF; adr = A_CTRL; wdat = 32'h3;
    rvalid = 1'b1; rseq = 64'h10; re = 20'd10;
    @(posedge clk); #1;
    rvalid = 1'b0;
    chk("t3_ack", {63'h0, ack}, 64'h1);
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    chk("t3_irq", {63'h0, irq}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rd_chk("t3_best_e", A_BEST_E, 32'h000F_FFFF);
    rd_chk("t3_evals",  A_EVALS,  32'h0);
    rd_chk("t3_status", A_STATUS, 32'h0);
    rd_chk("t3_ctrl",   A_CTRL,   32'h2);
    rd_chk("t3_thresh", A_THRESH, 32'd100);
    chk("t3_ready", {63'h0, rready}, 64'h1);

    // Test 4: SEQ_HI shadow stays coherent with the SEQ_LO read
    push(64'hDEAD_BEEF_0123_4567, 20'd200);
    repeat (2) @(posedge clk);
    #1;
    rd_chk("t4_seq_lo", A_SEQ_LO, 32'h0123_4567);
    push(64'h1111_2222_3333_4444, 20'd150);
    repeat (2) @(posedge clk);
    #1;
    rd_chk("t4_seq_hi",  A_SEQ_HI, 32'hDEAD_BEEF);
    rd_chk("t4_best_e",  A_BEST_E, 32'd150);
    rd_chk("t4_seq_lo2", A_SEQ_LO, 32'h3333_4444);
    rd_chk("t4_seq_hi2", A_SEQ_HI, 32'h1111_2222);

    // Test 5: six improvements 90..40
    wb_write(A_CTRL, 32'h1, 4'hF);
    for (int k = 0; k < 6; k++) push(64'(k), 20'(90 - 10 * k));
    repeat (3) @(posedge clk);
    #1;
    rd_chk("t5_best_e", A_BEST_E, 32'd40);
    rd_chk("t5_evals",  A_EVALS,  32'd6);
`ifdef LABS_TRACK_HIST_EN
    rd_chk("t5_status_full", A_STATUS, 32'h7);
    rd_chk("t5_hist0", A_HIST, 32'h8000_0046);
    rd_chk("t5_hist1", A_HIST, 32'h8000_003C);
    rd_chk("t5_hist2", A_HIST, 32'h8000_0032);
    rd_chk("t5_hist3", A_HIST, 32'h8000_0028);
    rd_chk("t5_status_empty", A_STATUS, 32'h3);
    rd_chk("t5_hist_empty", A_HIST, 32'h0);
`else
    rd_chk("t5_status", A_STATUS, 32'h3);
    rd_chk("t5_hist0", A_HIST, 32'h0);
    rd_chk("t5_hist1", A_HIST, 32'h0);
`endif

    // Test 6: asynchronous reset during a read
    chk("t6_irq_before", {63'h0, irq}, 64'h1);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF; adr = A_EVALS;
    #3 rst_n = 1'b0;
    #1;
    chk("t6_ack",   {63'h0, ack},    64'h0);
    chk("t6_irq",   {63'h0, irq},    64'h0);
    chk("t6_ready", {63'h0, rready}, 64'h0);
    chk("t6_dat",   {32'h0, rdat},   64'h0);
    @(posedge clk); #1;
    chk("t6_ack_edge", {63'h0, ack}, 64'h0);
    stb = 1'b0; cyc = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_ready_after", {63'h0, rready}, 64'h1);
    rd_chk("t6_status", A_STATUS, 32'h0);
    rd_chk("t6_evals",  A_EVALS,  32'h0);
    rd_chk("t6_best_e", A_BEST_E, 32'h000F_FFFF);
    rd_chk("t6_thresh", A_THRESH, 32'h0);
    rd_chk("t6_ctrl",   A_CTRL,   32'h0);
    rd_chk("t6_seq_lo", A_SEQ_LO, 32'h0);
    rd_chk("t6_seq_hi", A_SEQ_HI, 32'h0);
    rd_chk("t6_hist",   A_HIST,   32'h0);
    chk("t6_ties", {48'h0, dut.ties_q}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
